// File: rtl/regfile_writeback.sv
`timescale 1ns/1ps
// regfile_writeback: 2-read/1-write register file with a write-first bypass
// and a per-register busy scoreboard that stalls decode on pending producers.
module regfile_writeback #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 writeen,
  input  logic [ADDRWIDTH-1:0] writereg,
  input  logic [DATAWIDTH-1:0] writedata,
  input  logic                 issueen,
  input  logic [ADDRWIDTH-1:0] issuereg,
  input  logic [ADDRWIDTH-1:0] readreg1,
  input  logic [ADDRWIDTH-1:0] readreg2,
  output logic [DATAWIDTH-1:0] readdata1,
  output logic [DATAWIDTH-1:0] readdata2,
  output logic                 stall,
  output logic [ADDRWIDTH:0]   busycount
);

  localparam int NREGS = 2 ** ADDRWIDTH;
  localparam logic [ADDRWIDTH:0] CNT_ONE = 1;

  logic [DATAWIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0]     busy;
  logic [NREGS-1:0]     busy_next;
  logic [NREGS-1:0]     wr_hot;
  logic [NREGS-1:0]     iss_hot;
  logic                 wr_v;
  logic                 iss_v;
  logic                 cnt_inc;
  logic                 cnt_dec;
  logic                 stall1;
  logic                 stall2;

  // The bypass is gated by rstn so that reads show 0 while reset is held.
  assign wr_v  = writeen && rstn && (writereg != '0);
  assign iss_v = issueen && (issuereg != '0);

  always_comb begin
    wr_hot  = '0;
    iss_hot = '0;
    for (int i = 1; i < NREGS; i++) begin
      wr_hot[i]  = wr_v  && (writereg == ADDRWIDTH'(i));
      iss_hot[i] = iss_v && (issuereg == ADDRWIDTH'(i));
    end
  end

  // Issue is applied after the clear so a same-register issue leaves it busy.
  assign busy_next = (busy & ~wr_hot) | iss_hot;
  assign cnt_inc   = iss_v && !busy[issuereg];
  assign cnt_dec   = wr_v && busy[writereg] && !(iss_v && (issuereg == writereg));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy      <= '0;
      busycount <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wr_hot[i]) regs[i] <= writedata;
      end
      busy <= busy_next;
      if (cnt_inc && !cnt_dec)
        busycount <= busycount + CNT_ONE;
      else if (cnt_dec && !cnt_inc)
        busycount <= busycount - CNT_ONE;
    end
  end

  always_comb begin
    readdata1 = regs[readreg1];
    readdata2 = regs[readreg2];
    if (wr_v && (writereg == readreg1)) readdata1 = writedata;
    if (wr_v && (writereg == readreg2)) readdata2 = writedata;
  end

  assign stall1 = (readreg1 != '0) && busy[readreg1] && !(wr_v && (writereg == readreg1));
  assign stall2 = (readreg2 != '0) && busy[readreg2] && !(wr_v && (writereg == readreg2));
  assign stall  = stall1 || stall2;

endmodule

// File: tb/tb_regfile_writeback.sv
`timescale 1ns/1ps
// Directed bench for regfile_writeback: reset, write/read, bypass, scoreboard
// stall, same-cycle set/clear, full scoreboard and asynchronous reset.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rstn;
  logic        writeen;
  logic [4:0]  writereg;
  logic [31:0] writedata;
  logic        issueen;
  logic [4:0]  issuereg;
  logic [4:0]  readreg1;
  logic [4:0]  readreg2;
  logic [31:0] readdata1;
  logic [31:0] readdata2;
  logic        stall;
  logic [5:0]  busycount;

  int total = 0;
  int bad   = 0;

  regfile_writeback #(.DATAWIDTH(32), .ADDRWIDTH(5)) dut (
    .clk(clk), .rstn(rstn),
    .writeen(writeen), .writereg(writereg), .writedata(writedata),
    .issueen(issueen), .issuereg(issuereg),
    .readreg1(readreg1), .readreg2(readreg2),
    .readdata1(readdata1), .readdata2(readdata2),
    .stall(stall), .busycount(busycount)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    writeen = 1'b0; issueen = 1'b0;
    writereg = '0; writedata = '0; issuereg = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; idle(); readreg1 = '0; readreg2 = '0;
    tick();
    rstn = 1'b1;
    // preload some state so the reset has something to clear
    for (int i = 1; i < 4; i++) begin
      writeen = 1'b1; writereg = 5'(i); writedata = 32'h1000 + i;
      issueen = 1'b1; issuereg = 5'(i + 10);
      tick();
    end
    idle();
    readreg1 = 5'd2; #1;
    total++;
    if (readdata1 !== 32'h1002) begin bad++; $display("FAIL preload_rd got=%h exp=%h", readdata1, 32'h1002); end
    rstn = 1'b0; #1;
    total++;
    if (busycount !== 6'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", busycount); end
    tick();
    rstn = 1'b1;
    for (int i = 1; i < 32; i++) begin
      readreg1 = 5'(i); readreg2 = 5'(32 - i); #1;
      total++;
      if (readdata1 !== 32'h0 || readdata2 !== 32'h0 || stall !== 1'b0) begin
        bad++; $display("FAIL reset_read r%0d got=%h/%h stall=%b exp=0/0 stall=0", i, readdata1, readdata2, stall);
      end
    end
    total++;
    if (busycount !== 6'd0) begin bad++; $display("FAIL reset_cnt_after got=%0d exp=0", busycount); end
  endtask

  task automatic test_write();
    writeen = 1'b1; writereg = 5'd8; writedata = 32'hDEADBEEF;
    tick();
    idle(); readreg1 = 5'd8; readreg2 = 5'd9; #1;
    total++;
    if (readdata1 !== 32'hDEADBEEF) begin bad++; $display("FAIL write_r8 got=%h exp=deadbeef", readdata1); end
    total++;
    if (readdata2 !== 32'h0) begin bad++; $display("FAIL write_onehot_r9 got=%h exp=0", readdata2); end
    writeen = 1'b1; writereg = 5'd0; writedata = 32'h12345678; readreg2 = 5'd0; #1;
    total++;
    if (readdata2 !== 32'h0) begin bad++; $display("FAIL r0_bypass got=%h exp=0", readdata2); end
    tick();
    idle(); #1;
    total++;
    if (readdata2 !== 32'h0) begin bad++; $display("FAIL r0_write got=%h exp=0", readdata2); end
  endtask

  task automatic test_bypass();
    writeen = 1'b1; writereg = 5'd17; writedata = 32'hA5A5A5A5;
    readreg1 = 5'd17; readreg2 = 5'd17; #1;
    total++;
    if (readdata1 !== 32'hA5A5A5A5 || readdata2 !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL bypass got=%h/%h exp=a5a5a5a5", readdata1, readdata2);
    end
    tick();
    idle(); readreg2 = 5'd16; #1;
    total++;
    if (readdata1 !== 32'hA5A5A5A5 || readdata2 !== 32'h0) begin
      bad++; $display("FAIL bypass_stored got=%h/%h exp=a5a5a5a5/0", readdata1, readdata2);
    end
  endtask

  task automatic test_stall();
    issueen = 1'b1; issuereg = 5'd9; readreg1 = 5'd0; readreg2 = 5'd9; #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL issue_same_cycle stall=%b exp=0", stall); end
    tick();
    idle(); #1;
    total++;
    if (busycount !== 6'd1 || stall !== 1'b1) begin
      bad++; $display("FAIL stall_busy cnt=%0d stall=%b exp=1/1", busycount, stall);
    end
    writeen = 1'b1; writereg = 5'd9; writedata = 32'h55; #1;
    total++;
    if (stall !== 1'b0 || readdata2 !== 32'h55) begin
      bad++; $display("FAIL stall_bypass stall=%b rd2=%h exp=0/55", stall, readdata2);
    end
    tick();
    idle(); #1;
    total++;
    if (busycount !== 6'd0 || stall !== 1'b0) begin
      bad++; $display("FAIL stall_clear cnt=%0d stall=%b exp=0/0", busycount, stall);
    end
    issueen = 1'b1; issuereg = 5'd0;
    tick();
    idle(); #1;
    total++;
    if (busycount !== 6'd0 || stall !== 1'b0) begin
      bad++; $display("FAIL issue_r0 cnt=%0d stall=%b exp=0/0", busycount, stall);
    end
  endtask

  task automatic test_set_clear();
    issueen = 1'b1; issuereg = 5'd4;
    tick();
    writeen = 1'b1; writereg = 5'd4; writedata = 32'h77; issueen = 1'b1; issuereg = 5'd4;
    tick();
    idle(); readreg1 = 5'd4; readreg2 = 5'd0; #1;
    total++;
    if (busycount !== 6'd1 || readdata1 !== 32'h77 || stall !== 1'b1) begin
      bad++; $display("FAIL same_reg cnt=%0d rd1=%h stall=%b exp=1/77/1", busycount, readdata1, stall);
    end
    writeen = 1'b1; writereg = 5'd4; writedata = 32'h88; issueen = 1'b1; issuereg = 5'd5;
    tick();
    idle(); readreg2 = 5'd5; #1;
    total++;
    if (busycount !== 6'd1 || readdata1 !== 32'h88 || stall !== 1'b1) begin
      bad++; $display("FAIL net_zero cnt=%0d rd1=%h stall=%b exp=1/88/1", busycount, readdata1, stall);
    end
    readreg2 = 5'd0; #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL r4_not_busy stall=%b exp=0", stall); end
    issueen = 1'b1; issuereg = 5'd5;
    tick();
    writeen = 1'b1; writereg = 5'd4; writedata = 32'h99; issueen = 1'b0;
    tick();
    idle(); #1;
    total++;
    if (busycount !== 6'd1) begin bad++; $display("FAIL idempotent cnt=%0d exp=1", busycount); end
    writeen = 1'b1; writereg = 5'd5; writedata = 32'h5;
    tick();
    idle(); #1;
    total++;
    if (busycount !== 6'd0) begin bad++; $display("FAIL clear5 cnt=%0d exp=0", busycount); end
  endtask

  task automatic test_full();
    for (int i = 1; i < 32; i++) begin
      issueen = 1'b1; issuereg = 5'(i);
      tick();
    end
    issueen = 1'b1; issuereg = 5'd0;
    tick();
    idle(); readreg1 = 5'd20; readreg2 = 5'd0; #1;
    total++;
    if (busycount !== 6'd31 || stall !== 1'b1) begin
      bad++; $display("FAIL full cnt=%0d stall=%b exp=31/1", busycount, stall);
    end
    for (int i = 1; i < 32; i++) begin
      writeen = 1'b1; writereg = 5'(i); writedata = 32'h100 + i;
      tick();
    end
    idle(); readreg1 = 5'd31; #1;
    total++;
    if (busycount !== 6'd0 || stall !== 1'b0 || readdata1 !== 32'h11F) begin
      bad++; $display("FAIL drain cnt=%0d stall=%b rd1=%h exp=0/0/11f", busycount, stall, readdata1);
    end
  endtask

  task automatic test_reset_midop();
    issueen = 1'b1; issuereg = 5'd3;  tick();
    issueen = 1'b1; issuereg = 5'd6;  tick();
    issueen = 1'b1; issuereg = 5'd10; tick();
    idle();
    writeen = 1'b1; writereg = 5'd3; writedata = 32'hCAFE; readreg1 = 5'd6; readreg2 = 5'd10; #1;
    total++;
    if (busycount !== 6'd3 || stall !== 1'b1) begin
      bad++; $display("FAIL pre_reset cnt=%0d stall=%b exp=3/1", busycount, stall);
    end
    #1;
    rstn = 1'b0; readreg1 = 5'd17; readreg2 = 5'd3; #1;
    total++;
    if (busycount !== 6'd0 || stall !== 1'b0 || readdata1 !== 32'h0 || readdata2 !== 32'h0) begin
      bad++; $display("FAIL async_reset cnt=%0d stall=%b rd=%h/%h exp=0/0/0/0", busycount, stall, readdata1, readdata2);
    end
    tick();
    idle(); rstn = 1'b1; #1;
    total++;
    if (readdata2 !== 32'h0 || busycount !== 6'd0) begin
      bad++; $display("FAIL no_write_in_reset rd2=%h cnt=%0d exp=0/0", readdata2, busycount);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_bypass();
    test_stall();
    test_set_clear();
    test_full();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
